// File: rtl/spi_cmd_controller.sv
// Command sequencer between the SPI slave receive FIFO and a simple register bus.
// Parses a command word and a length word, then runs a write or read burst with auto-increment.
module spi_cmd_controller #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rx_read,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  abort
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StWrite,
        StFetch,
        StLoad,
        StStream
    } state_e;

    state_e                  state_q, state_d;
    logic                    dir_q, dir_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [2:0]              cs_sync_q;

    logic cs_rise;
    logic abort_evt;
    logic consume;
    logic pop;

    // Two flops resynchronise cs; the third only remembers the previous synced value.
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign abort_evt = cs_rise && (state_q != StIdle);

    assign consume = (state_q == StIdle) || (state_q == StLen) ||
                     (state_q == StWrite) || (state_q == StStream);

    // Gated by reset so no strobe escapes while reset is held.
    assign pop = reset && consume && !rx_empty && !abort_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            tx_q      <= '0;
            cs_sync_q <= '1;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
            cs_sync_q <= {cs_sync_q[1:0], cs};
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        count_d = count_q;
        tx_d    = tx_q;
        if (abort_evt) begin
            state_d = StIdle;
            tx_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        dir_d   = rx_data[DATA_WIDTH-1];
                        addr_d  = rx_data[ADDR_WIDTH-1:0];
                        state_d = StLen;
                    end
                end
                StLen: begin
                    if (pop) begin
                        count_d = rx_data;
                        if (rx_data == '0) begin
                            state_d = StIdle;
                        end else if (dir_q) begin
                            state_d = StWrite;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
                StWrite: begin
                    if (pop) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        count_d = count_q - DATA_WIDTH'(1);
                        if (count_q == DATA_WIDTH'(1)) begin
                            state_d = StIdle;
                        end
                    end
                end
                StFetch: begin
                    state_d = StLoad;
                end
                StLoad: begin
                    tx_d    = reg_rdata;
                    state_d = StStream;
                end
                StStream: begin
                    // The popped word is the master's dummy byte and is dropped.
                    if (pop) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        count_d = count_q - DATA_WIDTH'(1);
                        if (count_q == DATA_WIDTH'(1)) begin
                            state_d = StIdle;
                            tx_d    = '0;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        rx_read   = pop;
        reg_we    = (state_q == StWrite) && pop;
        reg_re    = reset && (state_q == StFetch) && !abort_evt;
        reg_wdata = reg_we ? rx_data : '0;
        reg_addr  = addr_q;
        tx_data   = tx_q;
        busy      = (state_q != StIdle);
        abort     = abort_evt;
    end

    strobe_exclusive_a : assert property (@(posedge clk) disable iff (!reset)
        !(reg_we && reg_re));

    abort_quiet_a : assert property (@(posedge clk) disable iff (!reset)
        abort |-> !(reg_we || reg_re || rx_read));

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: FIFO model, register read model and a
// negedge monitor that logs strobes; each test task checks its own scenario.
module tb_spi_cmd_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b1;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_read;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       abort;

    int errors = 0;
    int checks = 0;

    // FIFO model: initial block owns wr_ptr, the pop process owns rd_ptr.
    logic [7:0] fifo_mem [64];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;
    logic       starve = 1'b0;

    assign rx_empty = starve || (wr_ptr == rd_ptr);
    assign rx_data  = fifo_mem[rd_ptr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_read) rd_ptr <= rd_ptr + 6'd1;
        if (reg_re) reg_rdata <= {1'b0, reg_addr} + 8'h40;
    end

    // Monitor
    logic [11:0] cyc = 12'd0;
    logic [7:0]  tx_hist [4096];
    logic [7:0]  we_cnt = 8'd0, re_cnt = 8'd0, pop_cnt = 8'd0, ab_cnt = 8'd0, excl_viol = 8'd0;
    logic [6:0]  wlog_addr [256];
    logic [7:0]  wlog_data [256];
    logic [11:0] wlog_cyc [256];
    logic [6:0]  rlog_addr [256];
    logic [11:0] rlog_cyc [256];

    always @(negedge clk) begin
        cyc <= cyc + 12'd1;
        tx_hist[cyc] <= tx_data;
        if (reg_we) begin
            wlog_addr[we_cnt] <= reg_addr;
            wlog_data[we_cnt] <= reg_wdata;
            wlog_cyc[we_cnt]  <= cyc;
            we_cnt <= we_cnt + 8'd1;
        end
        if (reg_re) begin
            rlog_addr[re_cnt] <= reg_addr;
            rlog_cyc[re_cnt]  <= cyc;
            re_cnt <= re_cnt + 8'd1;
        end
        if (rx_read) pop_cnt <= pop_cnt + 8'd1;
        if (abort) ab_cnt <= ab_cnt + 8'd1;
        if (reg_we && reg_re) excl_viol <= excl_viol + 8'd1;
    end

    spi_cmd_controller #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(7)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_read  (rx_read),
        .tx_data  (tx_data),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .abort    (abort)
    );

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cs = 1'b1;
        push(8'h85);
        #3;
        checks++;
        if ({rx_read, busy, abort, reg_we, reg_re} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000", {rx_read, busy, abort, reg_we, reg_re});
        end
        checks++;
        if ({tx_data, reg_wdata, reg_addr} !== 23'd0) begin
            errors++;
            $display("FAIL reset_data: got tx=%h wdata=%h addr=%h want 0", tx_data, reg_wdata, reg_addr);
        end
        cycles(2);
        wr_ptr = rd_ptr;
        reset = 1'b1;
        cs = 1'b0;
        cycles(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_write();
        logic [7:0] bw, bp;
        bw = we_cnt;
        bp = pop_cnt;
        push(8'h85); push(8'h01); push(8'h3C);
        cycles(10);
        checks++;
        if (we_cnt - bw !== 8'd1) begin
            errors++;
            $display("FAIL single_we_count: got %0d want 1", we_cnt - bw);
        end
        checks++;
        if (wlog_addr[bw] !== 7'h05 || wlog_data[bw] !== 8'h3C) begin
            errors++;
            $display("FAIL single_write: got addr=%h data=%h want 05/3c", wlog_addr[bw], wlog_data[bw]);
        end
        checks++;
        if (pop_cnt - bp !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pops_busy: got pops=%0d busy=%b want 3/0", pop_cnt - bp, busy);
        end
    endtask

    task automatic test_write_wrap();
        logic [7:0] bw;
        logic [6:0] ea [3];
        logic [7:0] ed [3];
        ea = '{7'h7E, 7'h7F, 7'h00};
        ed = '{8'h11, 8'h22, 8'h33};
        bw = we_cnt;
        push(8'hFE); push(8'h03); push(8'h11); push(8'h22); push(8'h33);
        cycles(12);
        checks++;
        if (we_cnt - bw !== 8'd3) begin
            errors++;
            $display("FAIL wrap_we_count: got %0d want 3", we_cnt - bw);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wlog_addr[bw + 8'(i)] !== ea[i] || wlog_data[bw + 8'(i)] !== ed[i]) begin
                errors++;
                $display("FAIL wrap_write%0d: got addr=%h data=%h want %h/%h", i,
                         wlog_addr[bw + 8'(i)], wlog_data[bw + 8'(i)], ea[i], ed[i]);
            end
        end
        checks++;
        if (!(wlog_cyc[bw + 8'd1] > wlog_cyc[bw] && wlog_cyc[bw + 8'd2] > wlog_cyc[bw + 8'd1])) begin
            errors++;
            $display("FAIL wrap_distinct_cycles: got %0d %0d %0d want increasing",
                     wlog_cyc[bw], wlog_cyc[bw + 8'd1], wlog_cyc[bw + 8'd2]);
        end
    endtask

    task automatic test_read_burst();
        logic [7:0] br, bp, bw;
        br = re_cnt;
        bp = pop_cnt;
        bw = we_cnt;
        push(8'h10); push(8'h02); push(8'hD0); push(8'hD1);
        cycles(15);
        checks++;
        if (re_cnt - br !== 8'd2 || we_cnt - bw !== 8'd0) begin
            errors++;
            $display("FAIL read_strobe_count: got re=%0d we=%0d want 2/0", re_cnt - br, we_cnt - bw);
        end
        checks++;
        if (rlog_addr[br] !== 7'h10 || rlog_addr[br + 8'd1] !== 7'h11) begin
            errors++;
            $display("FAIL read_addrs: got %h %h want 10 11", rlog_addr[br], rlog_addr[br + 8'd1]);
        end
        checks++;
        if (tx_hist[rlog_cyc[br] + 12'd1] !== 8'h00 || tx_hist[rlog_cyc[br] + 12'd2] !== 8'h50) begin
            errors++;
            $display("FAIL read_tx0_timing: got +1=%h +2=%h want 00/50",
                     tx_hist[rlog_cyc[br] + 12'd1], tx_hist[rlog_cyc[br] + 12'd2]);
        end
        checks++;
        if (tx_hist[rlog_cyc[br + 8'd1] + 12'd2] !== 8'h51) begin
            errors++;
            $display("FAIL read_tx1: got %h want 51", tx_hist[rlog_cyc[br + 8'd1] + 12'd2]);
        end
        checks++;
        if (tx_data !== 8'h00 || pop_cnt - bp !== 8'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_end: got tx=%h pops=%0d busy=%b want 00/4/0", tx_data, pop_cnt - bp, busy);
        end
    endtask

    task automatic test_zero_length();
        logic [7:0] bw, br, bp;
        bw = we_cnt;
        br = re_cnt;
        bp = pop_cnt;
        push(8'h83); push(8'h00);
        cycles(6);
        checks++;
        if (busy !== 1'b0 || we_cnt - bw !== 8'd0 || re_cnt - br !== 8'd0 || pop_cnt - bp !== 8'd2) begin
            errors++;
            $display("FAIL zero_len: got busy=%b we=%0d re=%0d pops=%0d want 0/0/0/2",
                     busy, we_cnt - bw, re_cnt - br, pop_cnt - bp);
        end
        push(8'h85); push(8'h01); push(8'h77);
        cycles(8);
        checks++;
        if (we_cnt - bw !== 8'd1 || wlog_addr[bw] !== 7'h05 || wlog_data[bw] !== 8'h77) begin
            errors++;
            $display("FAIL zero_len_next: got we=%0d addr=%h data=%h want 1/05/77",
                     we_cnt - bw, wlog_addr[bw], wlog_data[bw]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] bw, ba;
        int n;
        bw = we_cnt;
        ba = ab_cnt;
        n = 0;
        push(8'h82); push(8'h04); push(8'hAA);
        while (we_cnt == bw && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (we_cnt - bw !== 8'd1) begin
            errors++;
            $display("FAIL abort_first_write: got %0d writes want 1 (waited %0d)", we_cnt - bw, n);
        end
        // Hide the next command until the abort cycle so it collides with it.
        starve = 1'b1;
        push(8'h85); push(8'h01); push(8'h66);
        cs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        starve = 1'b0;
        #1;
        checks++;
        if (abort !== 1'b1 || rx_read !== 1'b0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_wins: got abort=%b rx_read=%b we=%b want 1/0/0", abort, rx_read, reg_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b tx=%h want 0/00", busy, tx_data);
        end
        cycles(8);
        checks++;
        if (ab_cnt - ba !== 8'd1) begin
            errors++;
            $display("FAIL abort_pulses: got %0d want 1", ab_cnt - ba);
        end
        checks++;
        if (we_cnt - bw !== 8'd2 || wlog_addr[bw] !== 7'h02 || wlog_data[bw] !== 8'hAA ||
            wlog_addr[bw + 8'd1] !== 7'h05 || wlog_data[bw + 8'd1] !== 8'h66) begin
            errors++;
            $display("FAIL abort_writes: got n=%0d %h/%h %h/%h want 2 02/aa 05/66", we_cnt - bw,
                     wlog_addr[bw], wlog_data[bw], wlog_addr[bw + 8'd1], wlog_data[bw + 8'd1]);
        end
        cs = 1'b0;
        cycles(3);
    endtask

    task automatic test_starve_reset();
        logic [7:0] bw;
        bw = we_cnt;
        push(8'h81); push(8'h03);
        cycles(6);
        starve = 1'b1;
        push(8'h44); push(8'h55);
        cycles(5);
        checks++;
        if (busy !== 1'b1 || we_cnt - bw !== 8'd0 || rx_read !== 1'b0 || reg_re !== 1'b0) begin
            errors++;
            $display("FAIL starve_hold: got busy=%b we=%0d rx_read=%b re=%b want 1/0/0/0",
                     busy, we_cnt - bw, rx_read, reg_re);
        end
        @(negedge clk);
        #2;
        starve = 1'b0;
        #1;
        checks++;
        if (reg_we !== 1'b1 || reg_addr !== 7'h01 || reg_wdata !== 8'h44) begin
            errors++;
            $display("FAIL starve_release: got we=%b addr=%h data=%h want 1/01/44", reg_we, reg_addr, reg_wdata);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, abort, reg_we, reg_re, rx_read} !== 5'b0 || tx_data !== 8'h00 ||
            reg_addr !== 7'h00 || reg_wdata !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got flags=%b tx=%h addr=%h wdata=%h want 0",
                     {busy, abort, reg_we, reg_re, rx_read}, tx_data, reg_addr, reg_wdata);
        end
        cycles(3);
        checks++;
        if (we_cnt - bw !== 8'd0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes want 0", we_cnt - bw);
        end
        wr_ptr = rd_ptr;
        reset = 1'b1;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_wrap();
        test_read_burst();
        test_zero_length();
        test_abort();
        test_starve_reset();
        checks++;
        if (excl_viol !== 8'd0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", excl_viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
Command sequencer behind the buffered SPI slave and its receive FIFO. It pops received words from the FIFO and parses them as a command word followed by a length word. It then either streams write data into a register bus or fetches register contents onto the slave's transmit word (data_to_send). Auto-increment bursts are supported, and the burst is aborted when chip-select deasserts.

Parameters:
DATA_WIDTH, 8, SPI word width; must be >= ADDR_WIDTH+1
ADDR_WIDTH, 7, register address width; taken from command word bits [ADDR_WIDTH-1:0]

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cs  input  1  raw SPI chip-select, active-low, asynchronous to clk
rx_data  input  DATA_WIDTH  FIFO head word (show-ahead: valid whenever rx_empty=0)
rx_empty  input  1  FIFO empty flag
rx_read  output  1  FIFO pop strobe; one word per cycle
tx_data  output  DATA_WIDTH  word for the slave to shift out next (drives data_to_send)
reg_addr  output  ADDR_WIDTH  register bus address
reg_wdata  output  DATA_WIDTH  register write data
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  DATA_WIDTH  read data, valid the cycle after reg_re
busy  output  1  high in any state other than IDLE
abort  output  1  one-cycle pulse when a transaction is cut short by cs deassert

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0; address register 0; count 0; cs synchronizer preset to 1 (deasserted).
- cs passes through a 2-flop synchronizer. cs_rise = synced cs 0->1.
- rx_read = 1 only when rx_empty=0 and the current state consumes a word. A word is consumed in the same cycle rx_read is high.
- Command word: bit [DATA_WIDTH-1] = 1 means write, 0 means read. addr = bits [ADDR_WIDTH-1:0]. Bits in between are ignored.
- IDLE: pop a word, latch dir and addr, go to LEN. tx_data held at 0.
- LEN: pop a word as count N (DATA_WIDTH bits, unsigned).
  - N=0: go to IDLE with no bus access.
  - Write: go to WRITE.
  - Read: go to FETCH.
- WRITE: each popped word is written.
  - reg_we=1 in the pop cycle, with reg_addr=addr and reg_wdata=rx_data.
  - Next cycle: addr <= addr+1 (wraps modulo 2^ADDR_WIDTH), N <= N-1.
  - After the Nth write, go to IDLE.
- FETCH: reg_re=1 with reg_addr=addr for exactly one cycle, then go to LOAD.
- LOAD: tx_data <= reg_rdata (1 cycle after reg_re), then go to STREAM.
  - tx_data is therefore valid 2 clk after entering FETCH.
- STREAM: pop one dummy word (clocked in by the master during the shift-out), then discard it.
  - Then N <= N-1 and addr <= addr+1 (wraps).
  - N reaches 0: go to IDLE, tx_data <= 0.
  - Otherwise: go to FETCH.
- No pops occur in FETCH or LOAD. Words arriving meanwhile wait in the FIFO.
- cs_rise in any non-IDLE state:
  - go to IDLE next cycle; abort=1 for one cycle; tx_data <= 0.
  - No reg_we/reg_re/rx_read in that cycle: abort wins over a simultaneous pop.
- cs_rise in IDLE: ignored, no abort pulse.
- Reset mid-burst: immediate return to the reset values; no partial strobes are emitted after reset asserts.
- FIFO empty in any consuming state: hold state and outputs; no timeout.
- At most one of reg_we/reg_re is high in any cycle.

Test Plan:
- Single write: FIFO holds 0x85,0x01,0x3C -> reg_we pulses once with addr=0x05, wdata=0x3C; busy returns to 0; 3 pops.
- Write burst with wrap: 0xFE,0x03,0x11,0x22,0x33 -> writes at addrs 0x7E,0x7F,0x00 with data 0x11,0x22,0x33 on 3 distinct cycles.
- Read burst: 0x10,0x02,dummy,dummy with reg model returning addr+0x40 -> reg_re at 0x10 then 0x11; tx_data=0x50 then 0x51, each 2 clk after its fetch; tx_data=0 after the final dummy pop.
- Zero length: 0x83,0x00 -> no reg_we/reg_re; state back to IDLE after 2 pops; the next command parses normally.
- Abort: 0x82,0x04,0xAA, then cs raised -> exactly one write (addr 0x02, data 0xAA), abort pulses once, busy=0 within 4 clk, remaining FIFO words are parsed as a new command.
- Starved FIFO and reset: hold rx_empty=1 after the length word -> no strobes, state holds; assert reset mid-burst -> all outputs 0 asynchronously.
